dtmf_tone_gen: RTL and testbench

Two-channel programmable DTMF tone generator for the NIOS-integrated DTMF lab. It replaces the family of fixed single-frequency stepdown dividers with a single block. It accepts a 4-bit keypad code over a valid/ready handshake, then drives the matching row and column square waves for a fixed tone duration, followed by a silent inter-digit gap. It runs from the 1 MHz system clock and feeds the audio output pins or a 2-bit summing DAC.

---
 rtl/dtmf_tone_gen_pkg.sv | 31 +++
 rtl/dtmf_tone_gen_if.sv | 22 ++
 rtl/dtmf_tone_gen_tone_divider.sv | 33 +++
 rtl/dtmf_tone_gen.sv | 122 ++++++++++++
 tb/tb_dtmf_tone_gen.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtmf_tone_gen_pkg.sv
// Shared types, tone frequencies and divider tables for the DTMF tone generator.
package dtmf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_CLK_HZ = 1_000_000;

  // Row group (keypad code bits [3:2]) and column group (bits [1:0]), in Hz.
  localparam int ROW_FREQ [4] = '{697, 770, 852, 941};
  localparam int COL_FREQ [4] = '{1209, 1336, 1477, 1633};

  // Clocks per half period, rounded to nearest: round(clk_hz / (2*freq)).
  function automatic int half_period(input int clk_hz, input int freq);
    return (clk_hz + freq) / (2 * freq);
  endfunction

  // Half-period tables at the default 1 MHz system clock.
  localparam int ROW_DIV [4] = '{
    half_period(DEF_CLK_HZ, ROW_FREQ[0]), half_period(DEF_CLK_HZ, ROW_FREQ[1]),
    half_period(DEF_CLK_HZ, ROW_FREQ[2]), half_period(DEF_CLK_HZ, ROW_FREQ[3])
  };
  localparam int COL_DIV [4] = '{
    half_period(DEF_CLK_HZ, COL_FREQ[0]), half_period(DEF_CLK_HZ, COL_FREQ[1]),
    half_period(DEF_CLK_HZ, COL_FREQ[2]), half_period(DEF_CLK_HZ, COL_FREQ[3])
  };

endpackage

// File: rtl/dtmf_tone_gen_if.sv
// Keypad handshake and tone outputs of the DTMF tone generator.
interface dtmf_tone_gen_if;

  logic       key_valid;
  logic [3:0] key;
  logic       key_ready;
  logic       busy;
  logic       row_sq;
  logic       col_sq;
  logic [1:0] tone_sum;

  modport master (
    output key_valid, key,
    input  key_ready, busy, row_sq, col_sq, tone_sum
  );

  modport slave (
    input  key_valid, key,
    output key_ready, busy, row_sq, col_sq, tone_sum
  );

endinterface

// File: rtl/dtmf_tone_gen_tone_divider.sv
// Square-wave divider: each output half period lasts exactly div clocks.
module tone_divider #(
  parameter int CNT_W = 10
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             sq
);

  logic [CNT_W-1:0] count;

  // Half-period counter and output toggle; clr wins over a coincident toggle.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sq    <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sq    <= 1'b0;
    end else if (en) begin
      if (count == div - CNT_W'(1)) begin
        count <= '0;
        sq    <= ~sq;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dtmf_tone_gen.sv
// DTMF tone generator: accepts a keypad code, plays row+column tones, then a silent gap.
module dtmf_tone_gen
  import dtmf_pkg::*;
#(
  parameter int CLK_HZ   = 1_000_000,
  parameter int CNT_W    = 10,
  parameter int DUR_W    = 20,
  parameter int TONE_CYC = 100_000,
  parameter int GAP_CYC  = 50_000
) (
  input  logic           inclk,
  input  logic           rst_n,
  dtmf_tone_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] ROW_TAB [4] = '{
    CNT_W'(half_period(CLK_HZ, ROW_FREQ[0])), CNT_W'(half_period(CLK_HZ, ROW_FREQ[1])),
    CNT_W'(half_period(CLK_HZ, ROW_FREQ[2])), CNT_W'(half_period(CLK_HZ, ROW_FREQ[3]))
  };
  localparam logic [CNT_W-1:0] COL_TAB [4] = '{
    CNT_W'(half_period(CLK_HZ, COL_FREQ[0])), CNT_W'(half_period(CLK_HZ, COL_FREQ[1])),
    CNT_W'(half_period(CLK_HZ, COL_FREQ[2])), CNT_W'(half_period(CLK_HZ, COL_FREQ[3]))
  };
  localparam logic [DUR_W-1:0] TONE_LAST = DUR_W'(TONE_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [DUR_W-1:0] dur;
  logic [3:0]       key_lat;
  logic [1:0]       tone_sum_q;
  logic             accept;
  logic             tone_end;
  logic             gap_end;
  logic             div_clr;
  logic             div_en;
  logic             row_sq;
  logic             col_sq;

  // State register.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the one-cycle phase events that drive the counters.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tone_end  = 1'b0;
    gap_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.key_valid) begin
          accept    = 1'b1;
          state_nxt = ST_TONE;
        end
      end
      ST_TONE: begin
        if (dur == TONE_LAST) begin
          tone_end  = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (dur == GAP_LAST) begin
          gap_end   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Duration counter, restarted at every phase boundary.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n)                           dur <= '0;
    else if (accept || tone_end || gap_end) dur <= '0;
    else if (state != ST_IDLE)            dur <= dur + DUR_W'(1);
  end

  // Key latch; the code is frozen for the whole tone.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n)      key_lat <= 4'h0;
    else if (accept) key_lat <= bus.key;
  end

  // Registered DAC sum, held at zero from the last tone cycle onward.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n)                            tone_sum_q <= 2'd0;
    else if (state == ST_TONE && !tone_end) tone_sum_q <= {1'b0, row_sq} + {1'b0, col_sq};
    else                                   tone_sum_q <= 2'd0;
  end

  assign div_clr = accept | tone_end;
  assign div_en  = (state == ST_TONE);

  tone_divider #(.CNT_W(CNT_W)) u_row (
    .inclk (inclk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .div   (ROW_TAB[key_lat[3:2]]),
    .sq    (row_sq)
  );

  tone_divider #(.CNT_W(CNT_W)) u_col (
    .inclk (inclk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .div   (COL_TAB[key_lat[1:0]]),
    .sq    (col_sq)
  );

  assign bus.key_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.row_sq    = row_sq;
  assign bus.col_sq    = col_sq;
  assign bus.tone_sum  = tone_sum_q;

endmodule

// File: tb/tb_dtmf_tone_gen.sv
// Self-checking bench for dtmf_tone_gen with shortened tone/gap lengths.
module tb_dtmf_tone_gen;

  localparam int T_MAIN  = 3000;
  localparam int G_MAIN  = 200;
  localparam int T_SHORT = 1000;
  localparam int G_SHORT = 1;

  logic inclk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  int row_hz [4] = '{697, 770, 852, 941};
  int col_hz [4] = '{1209, 1336, 1477, 1633};

  always #5 inclk = ~inclk;

  dtmf_tone_gen_if bus ();
  dtmf_tone_gen_if bus_s ();

  dtmf_tone_gen #(
    .CLK_HZ(1_000_000), .CNT_W(10), .DUR_W(20), .TONE_CYC(T_MAIN), .GAP_CYC(G_MAIN)
  ) dut (
    .inclk (inclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dtmf_tone_gen #(
    .CLK_HZ(1_000_000), .CNT_W(10), .DUR_W(20), .TONE_CYC(T_SHORT), .GAP_CYC(G_SHORT)
  ) dut_s (
    .inclk (inclk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  // Ideal half period in clocks for a tone frequency at 1 MHz.
  function automatic int div_of(input int hz);
    return int'($floor(1.0e6 / (2.0 * hz) + 0.5));
  endfunction

  // Expected square-wave level t edges after the accepting edge.
  function automatic logic sq_at(input int t, input int div, input int tone);
    if (t < 0 || t >= tone) return 1'b0;
    return ((t / div) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    repeat (3) tick();
    got = {bus.key_ready, bus.busy, bus.row_sq, bus.col_sq, 1'b0};
    n_checks++;
    if (got !== 5'b10000 || bus.tone_sum !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got ready/busy/row/col=%b sum=%0d, expected 1000 sum=0", got[4:1], bus.tone_sum);
    end
    n_checks++;
    if (bus_s.key_ready !== 1'b1 || bus_s.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state_short: got ready=%b busy=%b, expected 1 0", bus_s.key_ready, bus_s.busy);
    end
    rst_n = 1'b1;
    tick();
    bus.key = 4'h5;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    repeat (700) tick();
    #2;
    n_checks++;
    if (bus.row_sq !== sq_at(700, div_of(770), T_MAIN) || bus.col_sq !== sq_at(700, div_of(1336), T_MAIN) || bus.tone_sum !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_tone: got row=%b col=%b sum=%0d, expected 1 1 2", bus.row_sq, bus.col_sq, bus.tone_sum);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.row_sq !== 1'b0 || bus.col_sq !== 1'b0 || bus.tone_sum !== 2'd0 || bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got row=%b col=%b sum=%0d busy=%b ready=%b, expected 0 0 0 0 1",
               bus.row_sq, bus.col_sq, bus.tone_sum, bus.busy, bus.key_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b, expected 1 0", bus.key_ready, bus.busy);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (bus.row_sq !== 1'b0 || bus.col_sq !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL post_reset_quiet i=%0d: got row=%b col=%b busy=%b, expected 0 0 0", i, bus.row_sq, bus.col_sq, bus.busy);
      end
    end
  endtask

  // One key through tone and gap, traced cycle by cycle against the model.
  task automatic test_tone(input logic [3:0] k, input int hr, input int hc, input bit noise);
    int w, last_r, last_c, tog_r, tog_c, es;
    logic prev_r, prev_c, er, ec, eb;
    bit seen [3];
    w = 0;
    while (bus.key_ready !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_wait key=%h: got ready=%b, expected 1", k, bus.key_ready);
    end
    bus.key = k;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key = 4'($urandom);
    last_r = 0; last_c = 0; tog_r = 0; tog_c = 0;
    prev_r = 1'b0; prev_c = 1'b0;
    seen = '{0, 0, 0};
    for (int t = 0; t <= T_MAIN + G_MAIN; t++) begin
      if (t > 0) tick();
      if (noise && t == 10) begin
        bus.key_valid = 1'b1;
        bus.key = 4'h3;
      end
      if (noise && t == 11) bus.key_valid = 1'b0;
      er = sq_at(t, hr, T_MAIN);
      ec = sq_at(t, hc, T_MAIN);
      eb = (t < T_MAIN + G_MAIN);
      es = (t >= 1 && t < T_MAIN) ? int'(sq_at(t - 1, hr, T_MAIN)) + int'(sq_at(t - 1, hc, T_MAIN)) : 0;
      n_checks++;
      if (bus.row_sq !== er) begin
        n_fail++;
        $display("[TB] FAIL row_sq key=%h t=%0d: got %b, expected %b", k, t, bus.row_sq, er);
      end
      n_checks++;
      if (bus.col_sq !== ec) begin
        n_fail++;
        $display("[TB] FAIL col_sq key=%h t=%0d: got %b, expected %b", k, t, bus.col_sq, ec);
      end
      n_checks++;
      if (bus.busy !== eb || bus.key_ready !== !eb) begin
        n_fail++;
        $display("[TB] FAIL busy_ready key=%h t=%0d: got busy=%b ready=%b, expected busy=%b", k, t, bus.busy, bus.key_ready, eb);
      end
      n_checks++;
      if (bus.tone_sum !== 2'(es)) begin
        n_fail++;
        $display("[TB] FAIL tone_sum key=%h t=%0d: got %0d, expected %0d", k, t, bus.tone_sum, es);
      end
      if (t < T_MAIN && bus.tone_sum !== 2'd3) seen[bus.tone_sum] = 1'b1;
      if (t > 0 && t < T_MAIN && bus.row_sq !== prev_r) begin
        n_checks++;
        if (t - last_r != hr) begin
          n_fail++;
          $display("[TB] FAIL row_half key=%h t=%0d: got %0d clocks, expected %0d", k, t, t - last_r, hr);
        end
        last_r = t;
        tog_r++;
      end
      if (t > 0 && t < T_MAIN && bus.col_sq !== prev_c) begin
        n_checks++;
        if (t - last_c != hc) begin
          n_fail++;
          $display("[TB] FAIL col_half key=%h t=%0d: got %0d clocks, expected %0d", k, t, t - last_c, hc);
        end
        last_c = t;
        tog_c++;
      end
      prev_r = bus.row_sq;
      prev_c = bus.col_sq;
    end
    n_checks++;
    if (tog_r < 2 || tog_c < 2) begin
      n_fail++;
      $display("[TB] FAIL toggle_count key=%h: got row=%0d col=%0d, expected at least 2 each", k, tog_r, tog_c);
    end
    n_checks++;
    if (!(seen[0] && seen[1] && seen[2])) begin
      n_fail++;
      $display("[TB] FAIL sum_levels key=%h: got seen0/1/2=%0d%0d%0d, expected 111", k, seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_random_keys();
    logic [3:0] k;
    for (int i = 0; i < 3; i++) begin
      k = 4'($urandom);
      test_tone(k, div_of(row_hz[k[3:2]]), div_of(col_hz[k[1:0]]), 1'($urandom));
    end
  endtask

  // key_valid held high: ready is seen after edge k+T+G, so the next key goes in on the following edge.
  task automatic test_back_to_back();
    logic [3:0] seq [3] = '{4'h1, 4'h2, 4'h3};
    logic er, ec, eb;
    int hr, hc;
    bus.key = seq[0];
    bus.key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hr = div_of(row_hz[seq[i][3:2]]);
      hc = div_of(col_hz[seq[i][1:0]]);
      tick();
      if (i < 2) bus.key = seq[i + 1];
      n_checks++;
      if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL held_accept tone=%0d: got busy=%b ready=%b, expected 1 0", i, bus.busy, bus.key_ready);
      end
      for (int t = 1; t <= T_MAIN + G_MAIN; t++) begin
        tick();
        er = sq_at(t, hr, T_MAIN);
        ec = sq_at(t, hc, T_MAIN);
        eb = (t < T_MAIN + G_MAIN);
        n_checks++;
        if (bus.row_sq !== er || bus.col_sq !== ec || bus.busy !== eb || bus.key_ready !== !eb) begin
          n_fail++;
          $display("[TB] FAIL held_trace tone=%0d t=%0d: got row=%b col=%b busy=%b ready=%b, expected %b %b %b %b",
                   i, t, bus.row_sq, bus.col_sq, bus.busy, bus.key_ready, er, ec, eb, !eb);
        end
      end
    end
    bus.key_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL held_release: got busy=%b ready=%b, expected 0 1", bus.busy, bus.key_ready);
    end
  endtask

  // Short tone: the row output is cut off in the middle of its second half period.
  task automatic test_short_tone();
    logic er, ec, eb;
    n_checks++;
    if (bus_s.key_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL short_ready: got %b, expected 1", bus_s.key_ready);
    end
    bus_s.key = 4'h0;
    bus_s.key_valid = 1'b1;
    tick();
    bus_s.key_valid = 1'b0;
    for (int t = 0; t <= T_SHORT + G_SHORT; t++) begin
      if (t > 0) tick();
      er = sq_at(t, 717, T_SHORT);
      ec = sq_at(t, 414, T_SHORT);
      eb = (t < T_SHORT + G_SHORT);
      n_checks++;
      if (bus_s.row_sq !== er || bus_s.col_sq !== ec || bus_s.busy !== eb || bus_s.key_ready !== !eb) begin
        n_fail++;
        $display("[TB] FAIL short_trace t=%0d: got row=%b col=%b busy=%b ready=%b, expected %b %b %b %b",
                 t, bus_s.row_sq, bus_s.col_sq, bus_s.busy, bus_s.key_ready, er, ec, eb, !eb);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key = 4'h0;
    bus_s.key_valid = 1'b0;
    bus_s.key = 4'h0;
    test_reset();
    test_tone(4'h0, 717, 414, 1'b0);
    test_tone(4'hF, 531, 306, 1'b0);
    test_tone(4'h6, div_of(row_hz[1]), div_of(col_hz[2]), 1'b1);
    test_random_keys();
    test_back_to_back();
    test_short_tone();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
